muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS core, downstream of the register file and ALU operand path.
- Consumes GPR rs/rt values plus a decoded op from ctrl, computes MULT/MULTU/DIV/DIVU over multiple cycles, and holds results in HI/LO for MFHI/MFLO through the DatatoReg path.
- Asserts busy so the core can stall PC update while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_unit_div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and default datapath width for the mul/div unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
// Purely combinational; no latency and no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] sh;

    // Remainder stays below divisor, so the shifted value needs only one extra bit.
    assign sh       = {rem, dvd_bit};
    assign q_bit    = (sh >= {1'b0, divisor});
    assign rem_next = q_bit ? WIDTH'(sh - {1'b0, divisor}) : sh[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; MTHI/MTLO write in one edge.
// Latency WIDTH+1 busy cycles (mult: 1 cycle when MULDIV_FAST_MUL_EN is defined).
// No backpressure: start is ignored while busy, core stalls on busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     raw_a;
    logic                 neg_q, neg_r, is_div;

    logic                 a_neg, b_neg, last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     rem_next;
    logic                 q_bit;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    // op[0] clear selects the signed variants of both MULT and DIV.
    assign a_neg = ~op[0] & rs_val[WIDTH-1];
    assign b_neg = ~op[0] & rt_val[WIDTH-1];
    assign a_mag = a_neg ? -rs_val : rs_val;
    assign b_mag = b_neg ? -rt_val : rt_val;
    assign last  = (cnt == CNT_W'(WIDTH - 1));
    assign busy  = (state_q != S_IDLE);

    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (prod[2*WIDTH-1:WIDTH]),
        .dvd_bit  (prod[WIDTH-1]),
        .divisor  (mcand),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (mcand == '0) begin
                fix_hi = raw_a;
                fix_lo = '1;
            end else begin
                if (neg_q) fix_lo = -prod[WIDTH-1:0];
                if (neg_r) fix_hi = -prod[2*WIDTH-1:WIDTH];
            end
        end else if (neg_q) begin
            {fix_hi, fix_lo} = -prod;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
`ifdef MULDIV_FAST_MUL_EN
                        OP_MULT, OP_MULTU: state_d = S_FIX;
`else
                        OP_MULT, OP_MULTU: state_d = S_MUL;
`endif
                        OP_DIV, OP_DIVU:   state_d = S_DIV;
                        default:           state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL:   if (last) state_d = S_FIX;
            S_DIV:   if (last) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            raw_a  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                cnt    <= '0;
                                mcand  <= b_mag;
                                raw_a  <= rs_val;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                is_div <= op[1];
`ifdef MULDIV_FAST_MUL_EN
                                if (!op[1]) prod <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                                else        prod <= {{WIDTH{1'b0}}, a_mag};
`else
                                prod   <= {{WIDTH{1'b0}}, a_mag};
`endif
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    prod <= {rem_next, prod[WIDTH-2:0], q_bit};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, done pulse, HI/LO results, reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, count busy cycles, then check done pulse and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int inject_at);
        int lat;
        int early_done;
        lat = 0;
        early_done = 0;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
        while (busy && lat < 100) begin
            if (done) early_done++;
            if (lat == inject_at) begin
                start = 1'b1; op = OP_MTHI; rs_val = 32'hA5A5_A5A5;
            end else begin
                start = 1'b0;
            end
            lat++;
            @(negedge clk);
        end
        start = 1'b0; rs_val = '0;
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".early_done"}, 64'(early_done), 64'd0);
        check({tag, ".done"}, {63'd0, done}, 64'd1);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        @(negedge clk);
        check({tag, ".done_clr"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b0; start = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.done", {63'd0, done}, 64'd0);
        check("rst.hi", {32'd0, hi}, 64'd0);
        check("rst.lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("multu_ff_x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE, -1);
        run_op("mult_m3_x7",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         DIV_LAT, 32'd2,         32'd14,        -1);
        run_op("divu_by0",    OP_DIVU,  32'h1234_5678, 32'h0000_0000, DIV_LAT, 32'h1234_5678, 32'hFFFF_FFFF, -1);
        run_op("div_by0",     OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
        run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000, -1);

        // MTHI then MTLO on back-to-back edges
        start = 1'b1; op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi.hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mthi.busy", {63'd0, busy}, 64'd0);
        check("mthi.done", {63'd0, done}, 64'd0);
        op = OP_MTLO; rs_val = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo.lo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
        check("mtlo.hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("mtlo.busy", {63'd0, busy}, 64'd0);
        check("mtlo.done", {63'd0, done}, 64'd0);

        // Reserved op codes must leave everything untouched
        start = 1'b1; op = 3'b110; rs_val = 32'h1111_2222; rt_val = 32'h3;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        check("rsvd.busy", {63'd0, busy}, 64'd0);
        check("rsvd.done", {63'd0, done}, 64'd0);
        check("rsvd.hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("rsvd.lo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});

        // A start (MTHI) arriving mid-divide must be ignored
        run_op("divu_inject", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 5);

        // Reset during the tenth busy cycle of a DIV aborts it
        start = 1'b1; op = OP_DIV; rs_val = 32'hFFFF_FFF9; rt_val = 32'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.hi", {32'd0, hi}, 64'd0);
        check("abort.lo", {32'd0, lo}, 64'd0);
        check("abort.done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort.quiet", 64'(seen), 64'd0);

        run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, MUL_LAT, 32'd0, 32'd15, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
